tlb_mp: RTL and testbench

- Parametrised, fully associative MIPS32 joint TLB. Serves N_PORTS independent translation ports (fetch, load/store, walker), each with a one-cycle registered result.
- Executes CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) through a command handshake.
- Owns the CP0 Random register, including Wired handling.
- Sits between the pipeline address stages and the cache front ends; the CP0 block supplies EntryHi, EntryLo0/1, Index and Wired.

---
 rtl/tlb_mp_if.sv | 59 +++++
 rtl/tlb_mp.sv | 254 +++++++++++++++++++++++++
 tb/tb_tlb_mp.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/tlb_mp_if.sv
// Lookup and CP0 command bundle for tlb_mp.
// Pagemask signals exist only when TLB_MP_PAGEMASK_EN is defined.
interface tlb_mp_if #(
    parameter int N_ENTRIES = 16,
    parameter int N_PORTS   = 2
);
    localparam int IW = $clog2(N_ENTRIES);

    logic [N_PORTS-1:0]    lk_valid;
    logic [32*N_PORTS-1:0] lk_vaddr;
    logic [7:0]            asid;
    logic [2:0]            k0;
    logic [N_PORTS-1:0]    lk_rvalid;
    logic [32*N_PORTS-1:0] lk_paddr;
    logic [N_PORTS-1:0]    lk_miss;
    logic [N_PORTS-1:0]    lk_inv;
    logic [N_PORTS-1:0]    lk_dirty;
    logic [3*N_PORTS-1:0]  lk_cattr;

    logic                  cmd_valid;
    logic [1:0]            cmd_op;
    logic                  cmd_ready;
    logic                  cmd_done;
    logic [31:0]           entryhi_i;
    logic [31:0]           entrylo0_i;
    logic [31:0]           entrylo1_i;
    logic [IW-1:0]         index_i;
    logic [IW-1:0]         wired_i;
    logic                  wired_we;
    logic [31:0]           index_o;
    logic [31:0]           entryhi_o;
    logic [31:0]           entrylo0_o;
    logic [31:0]           entrylo1_o;
    logic [IW-1:0]         random_o;
`ifdef TLB_MP_PAGEMASK_EN
    logic [24:13]          pagemask_i;
    logic [24:13]          pagemask_o;
`endif

    modport master (
`ifdef TLB_MP_PAGEMASK_EN
        output pagemask_i, input pagemask_o,
`endif
        output lk_valid, lk_vaddr, asid, k0,
        input  lk_rvalid, lk_paddr, lk_miss, lk_inv, lk_dirty, lk_cattr,
        output cmd_valid, cmd_op, entryhi_i, entrylo0_i, entrylo1_i, index_i, wired_i, wired_we,
        input  cmd_ready, cmd_done, index_o, entryhi_o, entrylo0_o, entrylo1_o, random_o
    );

    modport slave (
`ifdef TLB_MP_PAGEMASK_EN
        input pagemask_i, output pagemask_o,
`endif
        input  lk_valid, lk_vaddr, asid, k0,
        output lk_rvalid, lk_paddr, lk_miss, lk_inv, lk_dirty, lk_cattr,
        input  cmd_valid, cmd_op, entryhi_i, entrylo0_i, entrylo1_i, index_i, wired_i, wired_we,
        output cmd_ready, cmd_done, index_o, entryhi_o, entrylo0_o, entrylo1_o, random_o
    );
endinterface

// File: rtl/tlb_mp.sv
// Multi-port fully associative MIPS32 JTLB with CP0 TLBP/TLBR/TLBWI/TLBWR and Random.
// Define TLB_MP_PAGEMASK_EN for variable page sizes; default build uses fixed 4 KB pages.
module tlb_mp #(
    parameter int         N_ENTRIES = 16,
    parameter int         N_PORTS   = 2,
    parameter logic [2:0] K0_RESET  = 3'd3
) (
    input logic     clk,
    input logic     resetn,
    tlb_mp_if.slave bus
);
    localparam int            IW      = $clog2(N_ENTRIES);
    localparam logic [IW-1:0] TOP_IDX = IW'(N_ENTRIES - 1);
    localparam logic [1:0]    OP_TLBP = 2'd0;
    localparam logic [1:0]    OP_TLBR = 2'd1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    // EntryLo halves are stored as bits [25:1]: {PFN, C, D, V}
    logic [18:0] e_vpn2  [N_ENTRIES];
    logic [7:0]  e_asid  [N_ENTRIES];
    logic        e_g     [N_ENTRIES];
    logic [24:0] e_lo0   [N_ENTRIES];
    logic [24:0] e_lo1   [N_ENTRIES];
    logic [18:0] e_cmask [N_ENTRIES];
`ifdef TLB_MP_PAGEMASK_EN
    logic [11:0] e_mask  [N_ENTRIES];
    logic [11:0] mask_q;
    logic [11:0] pagemask_q;
`endif

    state_t        state;
    logic [1:0]    op_q;
    logic [18:0]   vpn2_q;
    logic [7:0]    asid_q;
    logic [24:0]   lo0_q, lo1_q;
    logic          g_q;
    logic [IW-1:0] idx_q, w_idx, random_q;
    logic          cmd_ready_q, cmd_done_q;
    logic [31:0]   index_q, ehi_q, elo0_q, elo1_q;
    logic [2:0]    k0_q;
    logic          p_hit;
    logic [IW-1:0] p_idx;

    logic [N_PORTS-1:0]    l_miss, l_inv, l_dirty, hit_p, odd_p;
    logic [31:0]           l_paddr [N_PORTS];
    logic [31:0]           va_p    [N_PORTS];
    logic [2:0]            l_cattr [N_PORTS];
    logic [IW-1:0]         hidx_p  [N_PORTS];
    logic [24:0]           lo_p    [N_PORTS];
    logic [N_PORTS-1:0]    rvalid_q, miss_q, inv_q, dirty_q;
    logic [32*N_PORTS-1:0] paddr_q;
    logic [3*N_PORTS-1:0]  cattr_q;

    logic unused_bits;
    assign unused_bits = ^{bus.entryhi_i[12:8], bus.entrylo0_i[31:26], bus.entrylo1_i[31:26]};

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
`ifdef TLB_MP_PAGEMASK_EN
            e_cmask[i] = {7'h7F, ~e_mask[i]};
`else
            e_cmask[i] = '1;
`endif
        end
    end

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        p_hit = 1'b0;
        p_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if ((((e_vpn2[i] ^ vpn2_q) & e_cmask[i]) == '0) && (e_g[i] || e_asid[i] == asid_q)) begin
                p_hit = 1'b1;
                p_idx = IW'(i);
            end
        end
    end

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            va_p[p]   = bus.lk_vaddr[32*p +: 32];
            hit_p[p]  = 1'b0;
            hidx_p[p] = '0;
            for (int i = N_ENTRIES - 1; i >= 0; i--) begin
                if ((((e_vpn2[i] ^ va_p[p][31:13]) & e_cmask[i]) == '0) &&
                    (e_g[i] || e_asid[i] == bus.asid)) begin
                    hit_p[p]  = 1'b1;
                    hidx_p[p] = IW'(i);
                end
            end
            odd_p[p] = va_p[p][12];
`ifdef TLB_MP_PAGEMASK_EN
            for (int k = 0; k < 12; k++)
                if (e_mask[hidx_p[p]][k]) odd_p[p] = va_p[p][13+k];
`endif
            lo_p[p]    = odd_p[p] ? e_lo1[hidx_p[p]] : e_lo0[hidx_p[p]];
            l_paddr[p] = {lo_p[p][24:5], va_p[p][11:0]};
`ifdef TLB_MP_PAGEMASK_EN
            l_paddr[p][23:12] = (lo_p[p][16:5] & ~e_mask[hidx_p[p]]) |
                                (va_p[p][23:12] & e_mask[hidx_p[p]]);
`endif
            l_cattr[p] = lo_p[p][4:2];
            l_miss[p]  = ~hit_p[p];
            l_inv[p]   = hit_p[p] & ~lo_p[p][0];
            l_dirty[p] = hit_p[p] & lo_p[p][1];
            // Unmapped segments are always writable, hence dirty=1
            if (va_p[p][31:30] == 2'b10) begin
                l_paddr[p] = {3'b000, va_p[p][28:0]};
                l_cattr[p] = va_p[p][29] ? 3'd2 : k0_q;
                l_miss[p]  = 1'b0;
                l_inv[p]   = 1'b0;
                l_dirty[p] = 1'b1;
            end
        end
    end

    // k0 is registered, so a Config.K0 change reaches kseg0 lookups one cycle later
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rvalid_q <= '0;
            miss_q   <= '0;
            inv_q    <= '0;
            dirty_q  <= '0;
            paddr_q  <= '0;
            cattr_q  <= '0;
            k0_q     <= K0_RESET;
        end else begin
            rvalid_q <= bus.lk_valid;
            miss_q   <= bus.lk_valid & l_miss;
            inv_q    <= bus.lk_valid & l_inv;
            dirty_q  <= bus.lk_valid & l_dirty;
            for (int p = 0; p < N_PORTS; p++) begin
                paddr_q[32*p +: 32] <= l_paddr[p];
                cattr_q[3*p +: 3]   <= l_cattr[p];
            end
            k0_q <= bus.k0;
        end
    end

    assign w_idx = op_q[0] ? random_q : idx_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                e_vpn2[i] <= '0;
                e_asid[i] <= '0;
                e_g[i]    <= 1'b0;
                e_lo0[i]  <= '0;
                e_lo1[i]  <= '0;
`ifdef TLB_MP_PAGEMASK_EN
                e_mask[i] <= '0;
`endif
            end
        end else if (state == EXEC && op_q[1]) begin
            e_vpn2[w_idx] <= vpn2_q;
            e_asid[w_idx] <= asid_q;
            e_g[w_idx]    <= g_q;
            e_lo0[w_idx]  <= lo0_q;
            e_lo1[w_idx]  <= lo1_q;
`ifdef TLB_MP_PAGEMASK_EN
            e_mask[w_idx] <= mask_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || bus.wired_we || random_q <= bus.wired_i)
            random_q <= TOP_IDX;
        else
            random_q <= random_q - IW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            index_q     <= 32'h8000_0000;
            ehi_q       <= '0;
            elo0_q      <= '0;
            elo1_q      <= '0;
            op_q        <= '0;
            vpn2_q      <= '0;
            asid_q      <= '0;
            lo0_q       <= '0;
            lo1_q       <= '0;
            g_q         <= 1'b0;
            idx_q       <= '0;
`ifdef TLB_MP_PAGEMASK_EN
            mask_q      <= '0;
            pagemask_q  <= '0;
`endif
        end else begin
            cmd_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        op_q        <= bus.cmd_op;
                        vpn2_q      <= bus.entryhi_i[31:13];
                        asid_q      <= bus.entryhi_i[7:0];
                        lo0_q       <= bus.entrylo0_i[25:1];
                        lo1_q       <= bus.entrylo1_i[25:1];
                        g_q         <= bus.entrylo0_i[0] & bus.entrylo1_i[0];
                        idx_q       <= bus.index_i;
`ifdef TLB_MP_PAGEMASK_EN
                        mask_q      <= bus.pagemask_i;
`endif
                        cmd_ready_q <= 1'b0;
                        state       <= EXEC;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (op_q == OP_TLBP)
                        index_q <= p_hit ? 32'(p_idx) : 32'h8000_0000;
                    if (op_q == OP_TLBR) begin
                        ehi_q  <= {e_vpn2[idx_q], 5'b00000, e_asid[idx_q]};
                        elo0_q <= {6'b000000, e_lo0[idx_q], e_g[idx_q]};
                        elo1_q <= {6'b000000, e_lo1[idx_q], e_g[idx_q]};
`ifdef TLB_MP_PAGEMASK_EN
                        pagemask_q <= e_mask[idx_q];
`endif
                    end
                    cmd_done_q <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    cmd_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.lk_rvalid  = rvalid_q;
    assign bus.lk_paddr   = paddr_q;
    assign bus.lk_miss    = miss_q;
    assign bus.lk_inv     = inv_q;
    assign bus.lk_dirty   = dirty_q;
    assign bus.lk_cattr   = cattr_q;
    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.cmd_done   = cmd_done_q;
    assign bus.index_o    = index_q;
    assign bus.entryhi_o  = ehi_q;
    assign bus.entrylo0_o = elo0_q;
    assign bus.entrylo1_o = elo1_q;
    assign bus.random_o   = random_q;
`ifdef TLB_MP_PAGEMASK_EN
    assign bus.pagemask_o = pagemask_q;
`endif
endmodule

// File: tb/tb_tlb_mp.sv
// Directed testbench for tlb_mp (default 16-entry, 2-port build, fixed 4 KB pages).
module tb_tlb_mp;
    localparam int N_ENTRIES = 16;
    localparam int N_PORTS   = 2;

    localparam logic [31:0] LO0_A  = 32'h0048_D15E;
    localparam logic [31:0] LO0_AG = 32'hFC48_D15F;
    localparam logic [31:0] LO0_B  = 32'h002A_AA83;
    localparam logic [31:0] LO1_G  = 32'h0000_0001;

    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tlb_mp_if #(.N_ENTRIES(N_ENTRIES), .N_PORTS(N_PORTS)) bus ();

    tlb_mp #(.N_ENTRIES(N_ENTRIES), .N_PORTS(N_PORTS), .K0_RESET(3'd3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] va0, input logic [31:0] va1);
        bus.lk_valid = valid;
        bus.lk_vaddr = {va1, va0};
        step();
        bus.lk_valid = '0;
    endtask

    task automatic waitReady();
        int cycles = 0;
        while (bus.cmd_ready !== 1'b1 && cycles < 20) begin
            step();
            cycles++;
        end
        checkOutput("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic issueCmd(input logic [1:0] op, input logic [31:0] ehi, input logic [31:0] lo0,
                            input logic [31:0] lo1, input logic [3:0] idx);
        waitReady();
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.entryhi_i  = ehi;
        bus.entrylo0_i = lo0;
        bus.entrylo1_i = lo1;
        bus.index_i    = idx;
        step();
        bus.cmd_valid = 1'b0;
        checkOutput("cmd_done_early", 32'(bus.cmd_done), 32'd0);
        step();
        checkOutput("cmd_done_pulse", 32'(bus.cmd_done), 32'd1);
        step();
        checkOutput("cmd_done_clear", 32'(bus.cmd_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn         = 1'b0;
        bus.lk_valid   = '0;
        bus.lk_vaddr   = '0;
        bus.asid       = 8'd0;
        bus.k0         = 3'd5;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'd0;
        bus.entryhi_i  = '0;
        bus.entrylo0_i = '0;
        bus.entrylo1_i = '0;
        bus.index_i    = '0;
        bus.wired_i    = '0;
        bus.wired_we   = 1'b0;
        step();
        step();

        checkOutput("rst_random", 32'(bus.random_o), 32'd15);
        checkOutput("rst_rvalid", 32'(bus.lk_rvalid), 32'd0);
        checkOutput("rst_miss", 32'(bus.lk_miss), 32'd0);
        checkOutput("rst_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("rst_done", 32'(bus.cmd_done), 32'd0);
        checkOutput("rst_index", bus.index_o, 32'h8000_0000);
        checkOutput("rst_entryhi", bus.entryhi_o, 32'd0);
        checkOutput("rst_entrylo0", bus.entrylo0_o, 32'd0);

        resetn = 1'b1;
        applyStimulus(2'b01, 32'h0040_0000, 32'h0);
        checkOutput("random_first_dec", 32'(bus.random_o), 32'd14);
        checkOutput("empty_rvalid", 32'(bus.lk_rvalid), 32'd1);
        checkOutput("empty_miss", 32'(bus.lk_miss), 32'd1);

        bus.asid = 8'd5;
        issueCmd(2'd2, 32'h0040_0005, LO0_A, 32'h0, 4'd3);
        applyStimulus(2'b11, 32'h0040_0ABC, 32'h0040_1ABC);
        checkOutput("hit_paddr0", bus.lk_paddr[31:0], 32'h1234_5ABC);
        checkOutput("hit_cattr0", 32'(bus.lk_cattr[2:0]), 32'd3);
        checkOutput("hit_rvalid", 32'(bus.lk_rvalid), 32'd3);
        checkOutput("hit_miss", 32'(bus.lk_miss), 32'd0);
        checkOutput("hit_inv", 32'(bus.lk_inv), 32'd2);
        checkOutput("hit_dirty", 32'(bus.lk_dirty), 32'd1);

        bus.asid = 8'd6;
        applyStimulus(2'b01, 32'h0040_0ABC, 32'h0);
        checkOutput("asid_miss", 32'(bus.lk_miss), 32'd1);

        issueCmd(2'd2, 32'h0040_0005, LO0_AG, LO1_G, 4'd3);
        applyStimulus(2'b01, 32'h0040_0ABC, 32'h0);
        checkOutput("global_miss", 32'(bus.lk_miss), 32'd0);
        checkOutput("global_paddr", bus.lk_paddr[31:0], 32'h1234_5ABC);

        issueCmd(2'd2, 32'h0040_0005, LO0_B, LO1_G, 4'd7);
        applyStimulus(2'b01, 32'h0040_0ABC, 32'h0);
        checkOutput("multi_lowest_paddr", bus.lk_paddr[31:0], 32'h1234_5ABC);

        issueCmd(2'd0, 32'h0040_0005, 32'h0, 32'h0, 4'd0);
        checkOutput("tlbp_hit", bus.index_o, 32'h0000_0003);
        issueCmd(2'd0, 32'h7FFF_E005, 32'h0, 32'h0, 4'd0);
        checkOutput("tlbp_miss", bus.index_o, 32'h8000_0000);

        issueCmd(2'd1, 32'h0, 32'h0, 32'h0, 4'd3);
        checkOutput("tlbr_entryhi", bus.entryhi_o, 32'h0040_0005);
        checkOutput("tlbr_entrylo0", bus.entrylo0_o, 32'h0048_D15F);
        checkOutput("tlbr_entrylo1", bus.entrylo1_o, 32'h0000_0001);
        checkOutput("tlbr_index_hold", bus.index_o, 32'h8000_0000);

        bus.wired_i  = 4'd4;
        bus.wired_we = 1'b1;
        issueCmd(2'd3, 32'h0200_0005, LO0_B, LO1_G, 4'd0);
        bus.wired_we = 1'b0;
        issueCmd(2'd0, 32'h0200_0005, 32'h0, 32'h0, 4'd0);
        checkOutput("tlbwr_top_idx", bus.index_o, 32'h0000_000F);

        bus.wired_we = 1'b1;
        step();
        checkOutput("wired_we_reload", 32'(bus.random_o), 32'd15);
        bus.wired_we = 1'b0;
        for (int k = 14; k >= 4; k--) begin
            step();
            checkOutput("random_dec", 32'(bus.random_o), 32'(k));
        end
        step();
        checkOutput("random_wrap", 32'(bus.random_o), 32'd15);

        for (int k = 0; k < 4; k++) begin
            issueCmd(2'd3, 32'h0100_0005 + (32'(k) << 13), LO0_B, LO1_G, 4'd0);
            issueCmd(2'd0, 32'h0100_0005 + (32'(k) << 13), 32'h0, 32'h0, 4'd0);
            checkOutput("tlbwr_above_wired",
                        32'(bus.index_o[31] == 1'b0 && bus.index_o[3:0] >= 4'd4), 32'd1);
        end
        issueCmd(2'd0, 32'h0040_0005, 32'h0, 32'h0, 4'd0);
        checkOutput("wired_entry_kept", bus.index_o, 32'h0000_0003);

        applyStimulus(2'b11, 32'hBFC0_0000, 32'h8000_1234);
        checkOutput("kseg1_paddr", bus.lk_paddr[31:0], 32'h1FC0_0000);
        checkOutput("kseg1_cattr", 32'(bus.lk_cattr[2:0]), 32'd2);
        checkOutput("kseg0_paddr", bus.lk_paddr[63:32], 32'h0000_1234);
        checkOutput("kseg0_cattr", 32'(bus.lk_cattr[5:3]), 32'd5);
        checkOutput("kseg_miss", 32'(bus.lk_miss), 32'd0);

        applyStimulus(2'b01, 32'h0050_0000, 32'h0);
        checkOutput("mapped_miss", 32'(bus.lk_miss), 32'd1);
        applyStimulus(2'b00, 32'h0050_0000, 32'h0);
        checkOutput("idle_rvalid", 32'(bus.lk_rvalid), 32'd0);
        checkOutput("idle_miss", 32'(bus.lk_miss), 32'd0);

        waitReady();
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = 2'd2;
        bus.entryhi_i  = 32'h0300_0005;
        bus.entrylo0_i = LO0_AG;
        bus.entrylo1_i = LO1_G;
        bus.index_i    = 4'd9;
        step();
        bus.cmd_valid = 1'b0;
        resetn        = 1'b0;
        step();
        checkOutput("midrst_done", 32'(bus.cmd_done), 32'd0);
        checkOutput("midrst_random", 32'(bus.random_o), 32'd15);
        checkOutput("midrst_index", bus.index_o, 32'h8000_0000);
        resetn = 1'b1;
        issueCmd(2'd1, 32'h0, 32'h0, 32'h0, 4'd9);
        checkOutput("midrst_entrylo0", bus.entrylo0_o, 32'd0);
        issueCmd(2'd0, 32'h0300_0005, 32'h0, 32'h0, 4'd0);
        checkOutput("midrst_tlbp", bus.index_o, 32'h8000_0000);
        applyStimulus(2'b01, 32'h0040_0ABC, 32'h0);
        checkOutput("midrst_cleared", 32'(bus.lk_miss), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
